// File: rtl/ptosda_tx.sv
// rtl/ptosda_tx.sv - parallel-to-serial scl/sda frame transmitter (START, MSB-first bits, STOP).
// Optional even parity bit after the data: define PTOSDA_TX_PARITY_EN.
module ptosda_tx #(
  parameter int HALF_DIV = 2,
  parameter int DATA_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              scl,
  output logic              sda,
  output logic              busy,
  output logic              done
);

`ifdef PTOSDA_TX_PARITY_EN
  localparam int SW = DATA_W + 1;
`else
  localparam int SW = DATA_W;
`endif
  localparam int BW = 5;
  localparam logic [7:0] HLAST = 8'(HALF_DIV - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_BIT_LO   = 3'd2;
  localparam logic [2:0] S_BIT_HI   = 3'd3;
  localparam logic [2:0] S_STOP_LO  = 3'd4;
  localparam logic [2:0] S_STOP_HI  = 3'd5;
  localparam logic [2:0] S_STOP_REL = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] shift_q, shift_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          done_q, done_d;
  logic [SW-1:0] load_w;
  logic [SW-1:0] shifted_w;

  // The parity bit simply rides as the last bit of the shift register.
`ifdef PTOSDA_TX_PARITY_EN
  assign load_w = {in_data, ^in_data};
`else
  assign load_w = in_data;
`endif
  assign shifted_w = shift_q << 1;

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign scl      = scl_q;
  assign sda      = sda_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (in_valid) begin
        shift_d = load_w;
        bit_d   = BW'(SW - 1);
        cnt_d   = 8'd0;
        state_d = S_START;
        scl_d   = 1'b1;
        sda_d   = 1'b0;
      end
    end else if (cnt_q != HLAST) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
      case (state_q)
        S_START: begin
          state_d = S_BIT_LO;
          scl_d   = 1'b0;
          sda_d   = shift_q[SW-1];
        end
        S_BIT_LO: begin
          state_d = S_BIT_HI;
          scl_d   = 1'b1;
        end
        S_BIT_HI: begin
          shift_d = shifted_w;
          scl_d   = 1'b0;
          if (bit_q == '0) begin
            state_d = S_STOP_LO;
            sda_d   = 1'b0;
          end else begin
            state_d = S_BIT_LO;
            bit_d   = bit_q - 1'b1;
            sda_d   = shifted_w[SW-1];
          end
        end
        S_STOP_LO: begin
          state_d = S_STOP_HI;
          scl_d   = 1'b1;
          sda_d   = 1'b0;
        end
        S_STOP_HI: begin
          state_d = S_STOP_REL;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= '0;
      shift_q <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ptosda_tx.sv
// tb/tb_ptosda_tx.sv - scoreboard bench for ptosda_tx at HALF_DIV=2 and HALF_DIV=1.
module tb_ptosda_tx;
  localparam int W = 4;
`ifdef PTOSDA_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N = W + PAR;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] in_valid, in_ready, scl, sda, busy, done;
  logic [W-1:0] in_data [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs = 0;
  int acc_cnt [2] = '{0, 0};

  typedef struct {
    logic [15:0] word;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int HD = (g == 0) ? 2 : 1;
    localparam int L  = (2 * N + 4) * HD;

    ptosda_tx #(.HALF_DIV(HD), .DATA_W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .scl      (scl[g]),
      .sda      (sda[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );

    int   ready_at = 0;
    int   start_cyc = 0;
    int   nbits = 0;
    int   bitsv = 0;
    logic ps = 1'b1, pd = 1'b1, in_frame = 1'b0, stopped = 1'b0;

    // Monitor: behavioural model of availability plus bus decode.
    always @(negedge clk) begin
      logic mr;
      exp_t e;
      int   eb;
      if (!rst_n) begin
        chk("rst_scl", int'(scl[g]), 1);
        chk("rst_sda", int'(sda[g]), 1);
        chk("rst_busy", int'(busy[g]), 0);
        chk("rst_done", int'(done[g]), 0);
        ready_at = 0;
        in_frame = 1'b0;
        stopped  = 1'b0;
        ps = 1'b1;
        pd = 1'b1;
        exp_q.delete();
      end else begin
        mr = (cyc >= ready_at);
        chk("in_ready", int'(in_ready[g]), int'(mr));
        chk("busy", int'(busy[g]), int'(!mr));
        if (done[g]) begin
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e  = exp_q.pop_front();
            eb = 0;
            for (int i = W - 1; i >= 0; i--) eb = (eb << 1) | int'(e.word[i]);
            if (PAR != 0) eb = (eb << 1) | int'(^e.word[W-1:0]);
            eb = eb << 1;
            chk("stop_seen", int'(stopped), 1);
            chk("scl_rises", nbits, N + 1);
            chk("bits", bitsv, eb);
            chk("frame_len", cyc - start_cyc, L);
            chk("done_lat", cyc - e.acc, L + 1);
          end
          stopped = 1'b0;
        end
        if (in_valid[g] && mr) begin
          exp_q.push_back('{16'(in_data[g]), cyc});
          ready_at = cyc + 1 + L;
          acc_cnt[g]++;
        end
        if (ps && scl[g] && pd && !sda[g]) begin
          chk("extra_start", int'(in_frame), 0);
          if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
          else chk("start_lat", cyc - exp_q[$].acc, 1);
          in_frame  = 1'b1;
          start_cyc = cyc;
          nbits = 0;
          bitsv = 0;
        end else if (ps && scl[g] && !pd && sda[g]) begin
          chk("stop_in_frame", int'(in_frame), 1);
          in_frame = 1'b0;
          stopped  = 1'b1;
        end else if (!ps && scl[g] && in_frame) begin
          nbits++;
          bitsv = (bitsv << 1) | int'(sda[g]);
        end
        ps = scl[g];
        pd = sda[g];
      end
    end
  end

  task automatic wait_acc(input int g);
    int c0 = acc_cnt[g];
    int t = 0;
    while (acc_cnt[g] == c0 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (acc_cnt[g] == c0) chk("accept_timeout", 0, 1);
  endtask

  task automatic drive(input int g, input logic [W-1:0] word);
    @(posedge clk);
    #1;
    in_data[g]  = word;
    in_valid[g] = 1'b1;
    wait_acc(g);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic random_run(input int g, input int ncyc);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      in_valid[g] = ($urandom % 3 == 0);
      in_data[g]  = W'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(0, 4'b1010);
    drain();

    @(posedge clk);
    #1;
    in_data[0]  = 4'b0001;
    in_valid[0] = 1'b1;
    wait_acc(0);
    @(posedge clk);
    #1;
    in_data[0] = 4'b1111;
    wait_acc(0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    drain();

    drive(0, 4'b0011);
    repeat (5) @(posedge clk);
    #1;
    in_data[0]  = 4'b0110;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    drain();

    // Abort during the second data bit, then confirm a clean next frame.
    drive(0, 4'b0101);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_scl", int'(scl[0]), 1);
    chk("abort_sda", int'(sda[0]), 1);
    chk("abort_busy", int'(busy[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 4'b1000);
    drain();

    drive(0, 4'b0111);
    drain();
    drive(0, 4'b0110);
    drain();

    random_run(0, 600);

    drive(1, 4'b0101);
    drain();
    random_run(1, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
